traffic_light_ctrl: RTL
=======================

# traffic_light_ctrl

Four-phase traffic-light controller with a pedestrian walk phase for a two-way (NS/EW) intersection. It sits directly downstream of the tick prescaler: the prescaler's 1-cycle `tick` pulse is the only time base, and every phase dwell is counted in ticks. Outputs are one-hot-per-direction lamp drives plus a walk lamp, decoded from the state register.

## Interface
- `NS_GREEN_TICKS`, default 5: NS green dwell in ticks (≥1)
- `EW_GREEN_TICKS`, default 5: EW green dwell in ticks (≥1)
- `YELLOW_TICKS`, default 2: yellow dwell for either direction, in ticks (≥1)
- `WALK_TICKS`, default 3: pedestrian walk dwell in ticks (≥1)
- `clk` in 1: system clock, same clock as the prescaler
- `rst` in 1: asynchronous, active-high reset
- `tick` in 1: 1-cycle time-base pulse from the prescaler
- `ped_req` in 1: pedestrian request, sampled every `clk`, level or pulse
- `ns_g`, `ns_y`, `ns_r` out 1 each: NS lamps
- `ew_g`, `ew_y`, `ew_r` out 1 each: EW lamps
- `walk` out 1: pedestrian walk lamp
- `ped_pending` out 1: a request is latched and not yet served

## Operation
- States: `NS_G`, `NS_Y`, `EW_G`, `EW_Y`, `WALK`.
- Dwell counter `cnt`:
  - Width is $clog2 of the maximum duration parameter, minimum 1 bit.
  - Increments on each `clk` with `tick`=1.
  - Resets to 0 on every state transition.
- Transition fires on a `clk` edge with `tick`=1 and `cnt` == DUR−1, where DUR is the dwell for the current state.
- Transitions:
  - `NS_G`→`NS_Y`
  - `NS_Y`→`WALK` if `ped_pending`, else `EW_G`
  - `EW_G`→`EW_Y`
  - `EW_Y`→`WALK` if `ped_pending`, else `NS_G`
  - `WALK`→ the green stored in `next_dir`. `next_dir` is captured on entry: `EW_G` when entered from `NS_Y`, `NS_G` when entered from `EW_Y`.
- The `ped_pending` decision uses the register value at the transition edge. A `ped_req` arriving in that same cycle is not considered for this yellow exit.
- `ped_pending` update each `clk`:
  - Cleared on the edge that enters `WALK`. Clear wins over a simultaneous `ped_req`.
  - Held 0 while in `WALK`. Requests during `WALK` are dropped.
  - Otherwise set when `ped_req`=1, and held until served.
- Green states never shorten on a request. A request is served only at the next yellow exit.
- Lamp decode (Moore, from the state register only):
  - `NS_G`: `ns_g` and `ew_r`
  - `NS_Y`: `ns_y` and `ew_r`
  - `EW_G`: `ew_g` and `ns_r`
  - `EW_Y`: `ew_y` and `ns_r`
  - `WALK`: `ns_r`, `ew_r` and `walk`
- Invariant: exactly one lamp per direction is lit. `walk`=1 implies `ns_r`=`ew_r`=1.
- Any unreachable state encoding recovers to `NS_G` on the next `clk` edge.

## Timing
- Reset (asynchronous assert, immediate effect):
  - state `NS_G`, `cnt`=0, `ped_pending`=0, `next_dir`=`NS_G`
  - outputs: `ns_g`=1, `ew_r`=1, all others 0
- Reset deassertion takes effect at the next `clk` edge.
- A state lasts exactly DUR ticks after entry. The tick that causes entry is consumed by the transition and is not counted.
- Outputs change in the same cycle the state register updates, i.e. one `clk` after the qualifying tick is sampled. There are no extra output registers.
- `tick` high on consecutive cycles counts once per cycle. TICK_HZ = CLK_FREQ_HZ is legal.
- `ped_pending` rises one `clk` after `ped_req` is sampled high.
- Reset mid-phase aborts immediately and discards any pending request.

## Test plan
- **Reset:** assert `rst` mid-`EW_Y` without a clock edge → outputs go to `ns_g`=1, `ew_r`=1, all others 0, and `ped_pending`=0 immediately. Deassert, then first tick → still `NS_G`, `cnt`=1.
- **Default cycle, `tick` every 4th clk, no requests:**
  - `NS_G` for 5 ticks, `NS_Y` for 2, `EW_G` for 5, `EW_Y` for 2, then back to `NS_G`.
  - Each transition lands exactly 1 clk after the qualifying tick. Lamp invariant is checked every cycle.
- **`ped_req` 1-cycle pulse during `NS_G` tick 2:**
  - `ped_pending`=1 next clk.
  - After `NS_Y` comes `WALK` for 3 ticks, with `walk`=1, `ns_r`=`ew_r`=1.
  - Then `EW_G`; `ped_pending`=0 from `WALK` entry.
- **`ped_req` held high across the `EW_Y`→`WALK` edge and through `WALK`:** `ped_pending`=0 during `WALK`. Exit goes to `NS_G`. `ped_pending`=1 one clk after the first `NS_G` cycle with `ped_req` still high.
- **Late request:** `ped_req` first asserted in the same cycle as the final `NS_Y` tick → goes to `EW_G`, not `WALK`. The request is served after `EW_Y`, then `WALK`, then `NS_G`.
- **`tick` tied high:** each phase lasts exactly DUR clk cycles (5/2/5/2). A full cycle takes 14 clks.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_ctrl
// Brief    : Tick-timed NS/EW traffic-light FSM with a pedestrian walk phase.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
   parameter int NS_GREEN_TICKS = 5,
   parameter int EW_GREEN_TICKS = 5,
   parameter int YELLOW_TICKS   = 2,
   parameter int WALK_TICKS     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic ped_req,
   output logic ns_g,
   output logic ns_y,
   output logic ns_r,
   output logic ew_g,
   output logic ew_y,
   output logic ew_r,
   output logic walk,
   output logic ped_pending
);

   localparam int c_MAX_G   = (NS_GREEN_TICKS > EW_GREEN_TICKS) ? NS_GREEN_TICKS : EW_GREEN_TICKS;
   localparam int c_MAX_YW  = (YELLOW_TICKS > WALK_TICKS) ? YELLOW_TICKS : WALK_TICKS;
   localparam int c_MAX_DUR = (c_MAX_G > c_MAX_YW) ? c_MAX_G : c_MAX_YW;
   localparam int c_CNT_W   = (c_MAX_DUR > 1) ? $clog2(c_MAX_DUR) : 1;

   localparam logic [c_CNT_W-1:0] c_NS_G_LAST = c_CNT_W'(NS_GREEN_TICKS - 1);
   localparam logic [c_CNT_W-1:0] c_EW_G_LAST = c_CNT_W'(EW_GREEN_TICKS - 1);
   localparam logic [c_CNT_W-1:0] c_Y_LAST    = c_CNT_W'(YELLOW_TICKS - 1);
   localparam logic [c_CNT_W-1:0] c_WALK_LAST = c_CNT_W'(WALK_TICKS - 1);

   // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
   localparam logic [6:0] c_LAMP_NS_G = 7'b1000010;
   localparam logic [6:0] c_LAMP_NS_Y = 7'b0100010;
   localparam logic [6:0] c_LAMP_EW_G = 7'b0011000;
   localparam logic [6:0] c_LAMP_EW_Y = 7'b0010100;
   localparam logic [6:0] c_LAMP_WALK = 7'b0010011;

   typedef enum logic [2:0] {
      ST_NS_G = 3'd0,
      ST_NS_Y = 3'd1,
      ST_EW_G = 3'd2,
      ST_EW_Y = 3'd3,
      ST_WALK = 3'd4
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_ped_pending;
   logic                 r_next_ew;
   logic [6:0]           r_lamps;

   logic [c_CNT_W-1:0]   w_last;
   state_t               w_adv;
   state_t               w_next;
   logic                 w_legal;
   logic                 w_fire;
   logic                 w_move;
   logic                 w_enter_walk;

   function automatic logic [6:0] f_lamps(input state_t s);
      case (s)
         ST_NS_Y: f_lamps = c_LAMP_NS_Y;
         ST_EW_G: f_lamps = c_LAMP_EW_G;
         ST_EW_Y: f_lamps = c_LAMP_EW_Y;
         ST_WALK: f_lamps = c_LAMP_WALK;
         default: f_lamps = c_LAMP_NS_G;
      endcase
   endfunction

   always_comb begin
      w_last  = '0;
      w_adv   = ST_NS_G;
      w_legal = 1'b1;
      case (r_state)
         ST_NS_G: begin
            w_last = c_NS_G_LAST;
            w_adv  = ST_NS_Y;
         end
         ST_NS_Y: begin
            w_last = c_Y_LAST;
            w_adv  = r_ped_pending ? ST_WALK : ST_EW_G;
         end
         ST_EW_G: begin
            w_last = c_EW_G_LAST;
            w_adv  = ST_EW_Y;
         end
         ST_EW_Y: begin
            w_last = c_Y_LAST;
            w_adv  = r_ped_pending ? ST_WALK : ST_NS_G;
         end
         ST_WALK: begin
            w_last = c_WALK_LAST;
            w_adv  = r_next_ew ? ST_EW_G : ST_NS_G;
         end
         default: w_legal = 1'b0;
      endcase
      w_fire       = tick && (r_cnt == w_last);
      // An illegal encoding moves to NS_G regardless of tick.
      w_move       = w_fire || !w_legal;
      w_next       = w_move ? w_adv : r_state;
      w_enter_walk = w_fire && (w_adv == ST_WALK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_NS_G;
         r_cnt         <= '0;
         r_ped_pending <= 1'b0;
         r_next_ew     <= 1'b0;
         r_lamps       <= c_LAMP_NS_G;
      end else begin
         r_state <= w_next;
         r_lamps <= f_lamps(w_next);
         if (w_move)
            r_cnt <= '0;
         else if (tick)
            r_cnt <= r_cnt + 1'b1;
         if (w_enter_walk)
            r_next_ew <= (r_state == ST_NS_Y);
         // Entering or sitting in WALK drops requests; clear beats a new request.
         if (w_enter_walk || (r_state == ST_WALK))
            r_ped_pending <= 1'b0;
         else if (ped_req)
            r_ped_pending <= 1'b1;
      end
   end

   assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} = r_lamps;
   assign ped_pending = r_ped_pending;

endmodule
`default_nettype wire
